// File: rtl/gate_test_pkg.sv
// ============================================================================
// gate_test_pkg : shared types and constants for the gate-unit test controller
// Rev 1.0
// ============================================================================
`default_nettype none

package gate_test_pkg;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned VEC_W       = 2;
  localparam int unsigned RESP_W      = 3;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Golden response {and, or, not-A} for vector v, where A = v[0], B = v[1]
  function automatic logic [RESP_W-1:0] expected_resp(input logic [VEC_W-1:0] v);
    logic a;
    logic b;
    a = v[0];
    b = v[1];
    return {a & b, a | b, ~a};
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_test_timer.sv
// ============================================================================
// gate_test_timer : reloadable settle down-counter, expires after HOLD_CYCLES
// Rev 1.0
// ============================================================================
`default_nettype none

module gate_test_timer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  // Loading HOLD_CYCLES-1 on entry makes expire assert on the last settle cycle
  localparam logic [7:0] C_RELOAD = 8'(HOLD_CYCLES - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= C_RELOAD;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign expire = (r_count == 8'd0);

endmodule

`default_nettype wire

// File: rtl/gate_test_ctrl.sv
// ============================================================================
// gate_test_ctrl : drives four (A,B) vectors into an external gate unit and
// checks its AND/OR/NOT responses. Optional macro GATE_TEST_LOOP_EN adds iLoop.
// Rev 1.0
// ============================================================================
`default_nettype none

module gate_test_ctrl
  import gate_test_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic       iAbort,
`ifdef GATE_TEST_LOOP_EN
  input  logic       iLoop,
`endif
  input  logic       iAnd,
  input  logic       iOr,
  input  logic       iNot,
  output logic       oA,
  output logic       oB,
  output logic       oBusy,
  output logic       oDone,
  output logic       oPass,
  output logic [3:0] oFailVec
);

  state_t           r_state;
  state_t           w_next_state;
  logic [VEC_W-1:0] r_vec;
  logic [3:0]       r_fail;
  logic             r_pass;
  logic             w_load;
  logic             w_expire;
  logic             w_loop;
  logic             w_start_ok;
  logic             w_mismatch;
  logic [3:0]       w_fail_upd;

`ifdef GATE_TEST_LOOP_EN
  assign w_loop = iLoop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_start_ok = iStart & ~iAbort;
  assign w_mismatch = ({iAnd, iOr, iNot} != expected_resp(r_vec));
  assign w_fail_upd = r_fail | (w_mismatch ? (4'b0001 << r_vec) : 4'b0000);

  gate_test_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk   (iClk),
    .rst_n (iRst_n),
    .load  (w_load),
    .expire(w_expire)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_next_state = ST_APPLY;
      ST_APPLY: begin
        if (iAbort)        w_next_state = ST_IDLE;
        else if (w_expire) w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (iAbort)                w_next_state = ST_IDLE;
        else if (r_vec == LAST_VEC) w_next_state = ST_DONE;
        else                       w_next_state = ST_APPLY;
      end
      ST_DONE: begin
        if (iAbort)      w_next_state = ST_IDLE;
        else if (w_loop) w_next_state = ST_APPLY;
        else             w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Reload the settle count on every entry into APPLY
    w_load = (w_next_state == ST_APPLY) && (r_state != ST_APPLY);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_vec  <= '0;
      r_fail <= 4'b0000;
      r_pass <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_start_ok) begin
        r_vec  <= '0;
        r_fail <= 4'b0000;
        r_pass <= 1'b0;
      end
    end else if (iAbort) begin
      r_vec  <= '0;
      r_pass <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      r_fail <= w_fail_upd;
      // Pass is resolved here so it is already valid during the oDone cycle
      if (r_vec == LAST_VEC) r_pass <= (w_fail_upd == 4'b0000);
      else                   r_vec  <= r_vec + 1'b1;
    end else if ((r_state == ST_DONE) && w_loop) begin
      r_vec  <= '0;
      r_fail <= 4'b0000;
    end
  end

  assign oA       = ((r_state == ST_APPLY) || (r_state == ST_CHECK)) & r_vec[0];
  assign oB       = ((r_state == ST_APPLY) || (r_state == ST_CHECK)) & r_vec[1];
  assign oBusy    = (r_state != ST_IDLE);
  assign oDone    = (r_state == ST_DONE) & ~iAbort;
  assign oPass    = r_pass;
  assign oFailVec = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_gate_test_ctrl.sv
// ============================================================================
// tb_gate_test_ctrl : directed self-checking bench with a behavioural gate unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gate_test_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       loop_in;
  logic       g_and, g_or, g_not;
  logic       o_a, o_b, busy, done, pass;
  logic [3:0] fail_vec;
  logic       stuck_or;

  int checks = 0;
  int errors = 0;

  // Results recorded by watch(); cycle 1 is the cycle after the accepting edge
  int         done_at [0:3];
  int         ndone;
  int         busy_cnt;
  logic       pass_at;
  logic [3:0] fv_at;
  int         vec_err;

  always #5 clk = ~clk;

  // External gate unit, with an optional stuck-at-0 OR output
  assign g_and = o_a & o_b;
  assign g_or  = stuck_or ? 1'b0 : (o_a | o_b);
  assign g_not = ~o_a;

  gate_test_ctrl #(.HOLD_CYCLES(4)) dut (
    .iClk    (clk),
    .iRst_n  (rst_n),
    .iStart  (start),
    .iAbort  (abort),
`ifdef GATE_TEST_LOOP_EN
    .iLoop   (loop_in),
`endif
    .iAnd    (g_and),
    .iOr     (g_or),
    .iNot    (g_not),
    .oA      (o_a),
    .oB      (o_b),
    .oBusy   (busy),
    .oDone   (done),
    .oPass   (pass),
    .oFailVec(fail_vec)
  );

  task automatic issue_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
  endtask

  // Observe ncyc cycles at the falling edge; optional one-cycle pulses on iStart
  // or iAbort at given cycles, and iLoop dropped at a given cycle (0 = never)
  task automatic watch(input int ncyc, input int start_at, input int abort_at, input int loop_drop);
    int cm;
    logic [1:0] ev;
    ndone = 0; busy_cnt = 0; pass_at = 1'bx; fv_at = 4'bx; vec_err = 0;
    for (int i = 0; i < 4; i++) done_at[i] = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        if (ndone == 0) begin pass_at = pass; fv_at = fail_vec; end
        if (ndone < 4) done_at[ndone] = c;
        ndone++;
      end else if (busy) begin
        cm = (c - 1) % 21;
        ev = 2'(cm / 5);
        if (cm < 20 && (o_a !== ev[0] || o_b !== ev[1])) vec_err++;
      end
      if (c == start_at)  start = 1'b1;
      if (c == abort_at)  abort = 1'b1;
      if (c == loop_drop) loop_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (pass !== 1'b0)       begin errors++; $display("FAIL reset_pass got=%b want=0", pass); end
    checks++; if (fail_vec !== 4'b0)   begin errors++; $display("FAIL reset_failvec got=%b want=0000", fail_vec); end
    checks++; if ({o_a, o_b} !== 2'b0) begin errors++; $display("FAIL reset_ab got=%b want=00", {o_a, o_b}); end
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    issue_start();
    watch(25, 0, 0, 0);
    checks++; if (done_at[0] !== 21) begin errors++; $display("FAIL normal_done_cycle got=%0d want=21", done_at[0]); end
    checks++; if (ndone !== 1)       begin errors++; $display("FAIL normal_done_count got=%0d want=1", ndone); end
    checks++; if (pass_at !== 1'b1)  begin errors++; $display("FAIL normal_pass got=%b want=1", pass_at); end
    checks++; if (fv_at !== 4'b0000) begin errors++; $display("FAIL normal_failvec got=%b want=0000", fv_at); end
    checks++; if (busy_cnt !== 21)   begin errors++; $display("FAIL normal_busy_cycles got=%0d want=21", busy_cnt); end
    checks++; if (vec_err !== 0)     begin errors++; $display("FAIL normal_vector_order got=%0d bad cycles want=0", vec_err); end
    checks++; if (pass !== 1'b1)     begin errors++; $display("FAIL normal_pass_hold got=%b want=1", pass); end
  endtask

  task automatic test_stuck_or();
    stuck_or = 1'b1;
    issue_start();
    watch(25, 0, 0, 0);
    stuck_or = 1'b0;
    checks++; if (done_at[0] !== 21) begin errors++; $display("FAIL stuck_done_cycle got=%0d want=21", done_at[0]); end
    checks++; if (fv_at !== 4'b1110) begin errors++; $display("FAIL stuck_failvec got=%b want=1110", fv_at); end
    checks++; if (pass_at !== 1'b0)  begin errors++; $display("FAIL stuck_pass got=%b want=0", pass_at); end
    checks++; if (fail_vec !== 4'b1110) begin errors++; $display("FAIL stuck_failvec_hold got=%b want=1110", fail_vec); end
  endtask

  task automatic test_abort();
    issue_start();
    watch(30, 0, 8, 0);
    checks++; if (ndone !== 0)         begin errors++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
    checks++; if (busy_cnt !== 8)      begin errors++; $display("FAIL abort_busy_cycles got=%0d want=8", busy_cnt); end
    checks++; if (pass !== 1'b0)       begin errors++; $display("FAIL abort_pass got=%b want=0", pass); end
    checks++; if ({o_a, o_b} !== 2'b0) begin errors++; $display("FAIL abort_ab got=%b want=00", {o_a, o_b}); end
    checks++; if (fail_vec !== 4'b0)   begin errors++; $display("FAIL abort_failvec got=%b want=0000", fail_vec); end
  endtask

  task automatic test_ignore_start();
    issue_start();
    watch(25, 5, 0, 0);
    checks++; if (done_at[0] !== 21) begin errors++; $display("FAIL restart_done_cycle got=%0d want=21", done_at[0]); end
    checks++; if (ndone !== 1)       begin errors++; $display("FAIL restart_done_count got=%0d want=1", ndone); end
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_idle busy got=%b want=0", busy); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL start_abort_pass_hold got=%b want=1", pass); end
  endtask

  task automatic test_async_reset();
    issue_start();
    repeat (3) @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL async_rst_busy got=%b want=0", busy); end
    checks++; if (pass !== 1'b0)       begin errors++; $display("FAIL async_rst_pass got=%b want=0", pass); end
    checks++; if ({o_a, o_b} !== 2'b0) begin errors++; $display("FAIL async_rst_ab got=%b want=00", {o_a, o_b}); end
    @(negedge clk);
    rst_n = 1'b1;
    issue_start();
    watch(25, 0, 0, 0);
    checks++; if (done_at[0] !== 21) begin errors++; $display("FAIL after_rst_done_cycle got=%0d want=21", done_at[0]); end
    checks++; if (pass_at !== 1'b1)  begin errors++; $display("FAIL after_rst_pass got=%b want=1", pass_at); end
  endtask

`ifdef GATE_TEST_LOOP_EN
  task automatic test_loop();
    loop_in = 1'b1;
    issue_start();
    watch(70, 0, 0, 50);
    checks++; if (ndone !== 3)       begin errors++; $display("FAIL loop_done_count got=%0d want=3", ndone); end
    checks++; if (done_at[0] !== 21 || done_at[1] !== 42 || done_at[2] !== 63) begin
      errors++; $display("FAIL loop_done_cycles got=%0d,%0d,%0d want=21,42,63", done_at[0], done_at[1], done_at[2]);
    end
    checks++; if (busy_cnt !== 63)   begin errors++; $display("FAIL loop_busy_cycles got=%0d want=63", busy_cnt); end
    checks++; if (pass !== 1'b1)     begin errors++; $display("FAIL loop_pass got=%b want=1", pass); end
    checks++; if (vec_err !== 0)     begin errors++; $display("FAIL loop_vector_order got=%0d want=0", vec_err); end
  endtask
`endif

  initial begin
    start = 1'b0; abort = 1'b0; loop_in = 1'b0; stuck_or = 1'b0; rst_n = 1'b1;
    test_reset();
    test_normal();
    test_stuck_or();
    test_abort();
    test_ignore_start();
    test_async_reset();
`ifdef GATE_TEST_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
